watch_set_ctrl: RTL and testbench
=================================

# watch_set_ctrl

Mode and time-set controller for the digital watch. Debounces the three user switches and runs the RUN/SET state machine. It drives `mode`, `set_pos` and `blink` to the FND display path, and issues single-cycle increment/clear commands and a run-enable to the hour/min/sec counters. It sits between the switch pins and the time counters in the watch top level, clocked from the system clock and using the 1 Hz and 2 Hz tick pulses from the clock divider.

## Interface
- `DB_CYCLES`, 500000: cycles a synchronized switch level must be stable before it is accepted (10 ms at 50 MHz).
- `TIMEOUT_S`, 30: seconds without a press in any SET state before automatic return to RUN; range 1–63.

- `clk` in 1: system clock; one clock domain.
- `reset` in 1: asynchronous, active-low reset.
- `sw0` in 1: raw mode switch, active-high, asynchronous.
- `sw1` in 1: raw position-select switch, active-high, asynchronous.
- `sw2` in 1: raw increment switch, active-high, asynchronous.
- `tick_1hz` in 1: one-`clk`-wide pulse once per second.
- `tick_2hz` in 1: one-`clk`-wide pulse twice per second.
- `mode` out 1: 0 = RUN, 1 = SET.
- `set_pos` out 3: one-hot field under edit; 100 = hour, 010 = min, 001 = sec, 000 = RUN.
- `blink` out 1: display enable for the selected field; 1 = lit.
- `run_en` out 1: time counters advance on `tick_1hz` only while high.
- `inc_hour` out 1: one-cycle pulse; the hour counter increments with its own wrap.
- `inc_min` out 1: one-cycle pulse; the minute counter increments with its own wrap.
- `clr_sec` out 1: one-cycle pulse; the seconds counter clears to 0.

## Operation
- Each switch path:
  - 2-FF synchronizer, then a stability counter.
  - The debounced level updates after the synchronized input has differed from it for `DB_CYCLES` consecutive cycles. Any bounce restarts the count.
  - A rising edge of the debounced level gives a one-cycle `press`. Falling edges are ignored.
- Debounced levels reset to 0. A switch held through reset therefore yields one press after debounce.
- FSM states: RUN, SET_HOUR, SET_MIN, SET_SEC. Reset state is RUN.
- Transitions and actions:
  - RUN + press0 → SET_HOUR.
  - Any SET state + press0 → RUN.
  - press1 in SET: HOUR → MIN → SEC → HOUR. press1 in RUN is ignored.
  - press2 in SET_HOUR → `inc_hour`; in SET_MIN → `inc_min`; in SET_SEC → `clr_sec`. press2 in RUN is ignored.
- Same-cycle presses: priority press0 > press1 > press2. Lower-priority presses in that cycle are discarded, not queued.
- Idle timer (6-bit):
  - Cleared on entering any SET state and on every accepted press.
  - Increments on `tick_1hz` while in SET.
  - Reaching `TIMEOUT_S` forces RUN and clears the timer.
- Timeout vs. press in the same cycle: the press wins and the timer clears.
- Derived outputs:
  - `mode` = (state ≠ RUN).
  - `run_en` = (state == RUN).
  - `set_pos` decodes from state.
- `blink`:
  - Forced to 1 in RUN.
  - Set to 1 on entry to any SET state and on every press1.
  - Otherwise toggles on each `tick_2hz` while in SET.

## Timing
- Reset values: `mode`=0, `set_pos`=000, `blink`=1, `run_en`=1, `inc_hour`=`inc_min`=`clr_sec`=0. Idle timer = 0; debounced levels = 0.
- Raw switch rising edge to `press`: 2 (sync) + `DB_CYCLES` + 1 cycles.
- `press` in cycle k → state, `mode`, `set_pos`, `run_en` and command pulses are registered outputs valid in cycle k+1.
- Command pulses are exactly one cycle wide; at most one command per accepted press.
- Timeout: the `tick_1hz` that brings the count to `TIMEOUT_S` in cycle k → RUN in k+1.
- Asynchronous reset mid-SET: immediate return to RUN with all reset values. A pending pulse is dropped.

## Structure
- Shared package `watch_pkg`:
  - State enum: RUN, SET_HOUR, SET_MIN, SET_SEC.
  - `set_pos` one-hot constants: `POS_HOUR`, `POS_MIN`, `POS_SEC`, `POS_NONE`.
  - Default `DB_CYCLES` and `TIMEOUT_S`.
- Sub-module `switch_debounce` (synchronizer + stability counter + rise-edge pulse), parameterized by `DB_CYCLES` and instantiated three times.
- FSM, idle timer and blink toggle stay in `watch_set_ctrl`.

## Test plan
Bench uses `DB_CYCLES`=4 and `TIMEOUT_S`=3.
- Reset: release reset → `mode`=0, `set_pos`=000, `blink`=1, `run_en`=1, no pulses.
- Debounce: sw0 bounces 1-0-1 at 1-cycle spacing, then holds high → exactly one press, `set_pos`=100 at 2+4+1+1 cycles after the last edge.
- Cycle and edit:
  - In SET_HOUR, press sw2 twice → two single-cycle `inc_hour`.
  - Press sw1 → `set_pos`=010; press sw2 → one `inc_min`.
  - Press sw1 → `set_pos`=001; press sw2 → one `clr_sec`.
- Priority: sw0 and sw2 pressed in the same cycle in SET_MIN → RUN, no `inc_min`.
- Timeout: enter SET, then 3 `tick_1hz` with no press → `mode`=0, `run_en`=1. A press landing in the same cycle as the 3rd tick keeps SET.
- Blink and reset: in SET, `blink` toggles on each `tick_2hz` and is forced to 1 on press1. Assert reset mid-SET → outputs return to reset values without waiting for `clk`.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared types and constants for the watch mode/time-set controller.
`timescale 1ns/1ps
package watch_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  localparam logic [2:0] POS_HOUR = 3'b100;
  localparam logic [2:0] POS_MIN  = 3'b010;
  localparam logic [2:0] POS_SEC  = 3'b001;
  localparam logic [2:0] POS_NONE = 3'b000;

  localparam int unsigned DEF_DB_CYCLES = 500000;
  localparam int unsigned DEF_TIMEOUT_S = 30;

  function automatic logic [2:0] pos_of(input state_t s);
    case (s)
      SET_HOUR: pos_of = POS_HOUR;
      SET_MIN:  pos_of = POS_MIN;
      SET_SEC:  pos_of = POS_SEC;
      default:  pos_of = POS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// One switch path: 2-FF synchronizer, stability counter, rising-edge press pulse.
`timescale 1ns/1ps
module switch_debounce
  import watch_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic press
);

  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= sw;
      sync2   <= sync1;
      level_q <= level;
      press   <= level & ~level_q;
      // Count only while the input disagrees; any agreement restarts the window.
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/watch_set_ctrl.sv
// RUN/SET controller: debounced switches drive field selection, edit commands,
// idle timeout back to RUN and the blink enable for the selected field.
`timescale 1ns/1ps
module watch_set_ctrl
  import watch_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DEF_DB_CYCLES,
  parameter int unsigned TIMEOUT_S = DEF_TIMEOUT_S
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw0,
  input  logic       sw1,
  input  logic       sw2,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  output logic       mode,
  output logic [2:0] set_pos,
  output logic       blink,
  output logic       run_en,
  output logic       inc_hour,
  output logic       inc_min,
  output logic       clr_sec
);

  localparam logic [5:0] TIMER_LAST = 6'(TIMEOUT_S - 1);

  logic       press0;
  logic       press1;
  logic       press2;

  state_t     state;
  state_t     state_nxt;
  logic       in_set;
  logic       accept;
  logic       rotate;
  logic [2:0] cmd_nxt;
  logic [2:0] cmd_q;
  logic [5:0] timer;
  logic       blink_q;

  switch_debounce #(.DB_CYCLES(DB_CYCLES)) u_db0 (
    .clk(clk), .reset(reset), .sw(sw0), .press(press0));
  switch_debounce #(.DB_CYCLES(DB_CYCLES)) u_db1 (
    .clk(clk), .reset(reset), .sw(sw1), .press(press1));
  switch_debounce #(.DB_CYCLES(DB_CYCLES)) u_db2 (
    .clk(clk), .reset(reset), .sw(sw2), .press(press2));

  assign in_set = (state != RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  // press0 > press1 > press2 > timeout; losers in the same cycle are dropped.
  always_comb begin
    state_nxt = state;
    cmd_nxt   = 3'b000;
    accept    = 1'b0;
    rotate    = 1'b0;
    if (press0) begin
      accept    = 1'b1;
      state_nxt = in_set ? RUN : SET_HOUR;
    end else if (in_set && press1) begin
      accept = 1'b1;
      rotate = 1'b1;
      case (state)
        SET_HOUR: state_nxt = SET_MIN;
        SET_MIN:  state_nxt = SET_SEC;
        default:  state_nxt = SET_HOUR;
      endcase
    end else if (in_set && press2) begin
      accept = 1'b1;
      case (state)
        SET_HOUR: cmd_nxt = 3'b100;
        SET_MIN:  cmd_nxt = 3'b010;
        SET_SEC:  cmd_nxt = 3'b001;
        default:  cmd_nxt = 3'b000;
      endcase
    end else if (in_set && tick_1hz && (timer == TIMER_LAST)) begin
      state_nxt = RUN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_q   <= 3'b000;
      timer   <= 6'd0;
      blink_q <= 1'b1;
    end else begin
      cmd_q <= cmd_nxt;

      if (!in_set || accept)  timer <= 6'd0;
      else if (tick_1hz)      timer <= (timer == TIMER_LAST) ? 6'd0 : timer + 6'd1;

      if (state_nxt == RUN)       blink_q <= 1'b1;
      else if (!in_set || rotate) blink_q <= 1'b1;
      else if (tick_2hz)          blink_q <= ~blink_q;
    end
  end

  always_comb begin
    mode     = in_set;
    run_en   = ~in_set;
    set_pos  = pos_of(state);
    blink    = blink_q;
    inc_hour = cmd_q[2];
    inc_min  = cmd_q[1];
    clr_sec  = cmd_q[0];
  end

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Directed bench for watch_set_ctrl with short debounce and timeout settings.
`timescale 1ns/1ps
module tb_watch_set_ctrl;

  localparam int DB = 4;

  logic       clk;
  logic       reset;
  logic       sw0, sw1, sw2;
  logic       tick_1hz, tick_2hz;
  logic       mode;
  logic [2:0] set_pos;
  logic       blink;
  logic       run_en;
  logic       inc_hour, inc_min, clr_sec;

  int n_checks = 0;
  int n_pass   = 0;
  logic [2:0] exp_q[$];

  watch_set_ctrl #(.DB_CYCLES(DB), .TIMEOUT_S(3)) dut (
    .clk(clk), .reset(reset),
    .sw0(sw0), .sw1(sw1), .sw2(sw2),
    .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .mode(mode), .set_pos(set_pos), .blink(blink), .run_en(run_en),
    .inc_hour(inc_hour), .inc_min(inc_min), .clr_sec(clr_sec)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  // scoreboard for command pulses: every pulse cycle must match the next expected command
  always @(negedge clk) begin
    if (reset && (inc_hour || inc_min || clr_sec)) begin
      if (exp_q.size() == 0) check("unexpected_cmd", {29'd0, inc_hour, inc_min, clr_sec}, 32'd0);
      else                   check("cmd_order", {29'd0, inc_hour, inc_min, clr_sec}, {29'd0, exp_q.pop_front()});
    end
  end

  // driver tasks: all start and end 1 ns after a rising edge
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick1();
    tick_1hz = 1'b1;
    cycles(1);
    tick_1hz = 1'b0;
  endtask

  task automatic tick2();
    tick_2hz = 1'b1;
    cycles(1);
    tick_2hz = 1'b0;
  endtask

  task automatic set_sw(input logic [2:0] sws);
    sw0 = sws[0];
    sw1 = sws[1];
    sw2 = sws[2];
  endtask

  // press: switch rises, FSM reacts DB+4 edges later; pulse must last one cycle
  task automatic press_sw(input logic [2:0] sws, input logic [2:0] exp_cmd);
    if (exp_cmd != 3'b000) exp_q.push_back(exp_cmd);
    set_sw(sws);
    cycles(DB + 4);
    check("cmd_k1", {29'd0, inc_hour, inc_min, clr_sec}, {29'd0, exp_cmd});
    cycles(1);
    check("cmd_width", {29'd0, inc_hour, inc_min, clr_sec}, 32'd0);
    set_sw(3'b000);
    cycles(DB + 4);
  endtask

  task automatic check_outs(input string tag, input logic m, input logic [2:0] p,
                            input logic b, input logic r);
    check({tag, "_mode"},    {31'd0, mode},    {31'd0, m});
    check({tag, "_set_pos"}, {29'd0, set_pos}, {29'd0, p});
    check({tag, "_blink"},   {31'd0, blink},   {31'd0, b});
    check({tag, "_run_en"},  {31'd0, run_en},  {31'd0, r});
  endtask

  initial begin
    reset = 1'b0;
    set_sw(3'b000);
    tick_1hz = 1'b0;
    tick_2hz = 1'b0;
    cycles(3);
    check_outs("in_reset", 1'b0, 3'b000, 1'b1, 1'b1);
    check("in_reset_cmd", {29'd0, inc_hour, inc_min, clr_sec}, 32'd0);
    reset = 1'b1;
    cycles(2);
    check_outs("after_reset", 1'b0, 3'b000, 1'b1, 1'b1);

    // bounce 1-0-1 on sw0, then hold: one press, SET_HOUR 8 edges after last edge
    sw0 = 1'b1; cycles(1);
    sw0 = 1'b0; cycles(1);
    sw0 = 1'b1;
    cycles(7);
    check("bounce_early_pos", {29'd0, set_pos}, 32'd0);
    cycles(1);
    check_outs("bounce_set", 1'b1, 3'b100, 1'b1, 1'b0);
    cycles(20);
    check("bounce_single_press", {29'd0, set_pos}, 32'b100);
    sw0 = 1'b0;
    cycles(DB + 4);

    // blink toggles on 2 Hz ticks
    tick2(); check("blink_t1", {31'd0, blink}, 32'd0);
    tick2(); check("blink_t2", {31'd0, blink}, 32'd1);
    tick2(); check("blink_t3", {31'd0, blink}, 32'd0);

    // edits in each field
    press_sw(3'b100, 3'b100);
    press_sw(3'b100, 3'b100);
    check("hour_pos", {29'd0, set_pos}, 32'b100);
    press_sw(3'b010, 3'b000);
    check_outs("to_min", 1'b1, 3'b010, 1'b1, 1'b0);
    press_sw(3'b100, 3'b010);
    press_sw(3'b010, 3'b000);
    check("to_sec", {29'd0, set_pos}, 32'b001);
    press_sw(3'b100, 3'b001);
    press_sw(3'b010, 3'b000);
    check("wrap_hour", {29'd0, set_pos}, 32'b100);
    press_sw(3'b010, 3'b000);
    check("min_again", {29'd0, set_pos}, 32'b010);

    // sw0 and sw2 together in SET_MIN: exit, no inc_min
    press_sw(3'b101, 3'b000);
    check_outs("prio_exit", 1'b0, 3'b000, 1'b1, 1'b1);

    // sw1/sw2 ignored in RUN; blink stays lit
    press_sw(3'b010, 3'b000);
    check("run_ign_sw1", {29'd0, set_pos}, 32'd0);
    press_sw(3'b100, 3'b000);
    check("run_ign_sw2", {31'd0, mode}, 32'd0);
    tick2();
    check("run_blink", {31'd0, blink}, 32'd1);

    // timeout after 3 silent seconds
    press_sw(3'b001, 3'b000);
    tick1(); tick1();
    check("to_before", {31'd0, mode}, 32'd1);
    tick1();
    check_outs("to_after", 1'b0, 3'b000, 1'b1, 1'b1);

    // press coinciding with the 3rd tick keeps SET and restarts the timer
    press_sw(3'b001, 3'b000);
    tick1(); tick1();
    sw1 = 1'b1;
    cycles(DB + 3);
    tick_1hz = 1'b1;
    cycles(1);
    tick_1hz = 1'b0;
    check_outs("to_race", 1'b1, 3'b010, 1'b1, 1'b0);
    sw1 = 1'b0;
    cycles(DB + 4);
    tick1(); tick1();
    check("to_restart_hold", {31'd0, mode}, 32'd1);
    tick1();
    check("to_restart_exit", {31'd0, mode}, 32'd0);

    // asynchronous reset mid-SET
    press_sw(3'b001, 3'b000);
    tick2();
    check("pre_rst_blink", {31'd0, blink}, 32'd0);
    #2 reset = 1'b0;
    #1 check_outs("async_rst", 1'b0, 3'b000, 1'b1, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    cycles(2);
    check_outs("post_rst", 1'b0, 3'b000, 1'b1, 1'b1);

    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
